// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences weight load, padded feature-map streaming and result capture for one conv pass.
// Optional drain timeout with o_err is enabled by defining CONV_SEQ_CTRL_TIMEOUT_EN.
module conv_seq_ctrl #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE = 4,
  parameter int PADDING = 0,
  parameter int STRIDE = 1,
  parameter int DATA_W = 30,
  parameter int WEIGHT_W = 18,
  parameter int RES_W = 48,
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE,
  localparam int NN = FM_SIZE * FM_SIZE,
  localparam int PN = FM_SIZE + 2 * PADDING,
  localparam int OUT = (FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1,
  localparam int NRES = OUT * OUT,
  localparam int WA_W = KK > 1 ? $clog2(KK) : 1,
  localparam int FA_W = NN > 1 ? $clog2(NN) : 1,
  localparam int RA_W = NRES > 1 ? $clog2(NRES) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_go,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [WA_W-1:0]          o_w_addr,
  input  logic [WEIGHT_W-1:0]      i_w_data,
  output logic [FA_W-1:0]          o_fm_addr,
  output logic                     o_fm_rd,
  input  logic [DATA_W-1:0]        i_fm_data,
  output logic [KK*WEIGHT_W-1:0]   o_weight,
  output logic [DATA_W-1:0]        o_pe_data,
  output logic                     o_pe_en,
  input  logic                     i_res_en,
  input  logic [RES_W-1:0]         i_res_data,
  output logic [RA_W-1:0]          o_res_addr,
  output logic                     o_res_wr,
  output logic [RES_W-1:0]         o_res_data
);
  localparam int WC_W = $clog2(KK + 1);
  localparam int RC_W = PN > 1 ? $clog2(PN) : 1;
  localparam int CNT_W = $clog2(NRES + 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t state;
  logic [WC_W-1:0] w_cnt;
  logic [RC_W-1:0] r, c;
  logic [CNT_W-1:0] res_cnt;
  logic pad_q, last_pos, p_in;
  logic [DATA_W-1:0] last_q;
  logic [FA_W-1:0] p_addr;
  int pr, pc, ir, ic;
`ifdef CONV_SEQ_CTRL_TIMEOUT_EN
  logic [15:0] idle_cnt;
`else
  assign o_err = 1'b0;
`endif
  // next raster position to issue: (0,0) when entering STREAM, else the successor of (r,c)
  always_comb begin
    last_pos = int'(r) == PN - 1 && int'(c) == PN - 1;
    pc = state == STREAM ? (int'(c) == PN - 1 ? 0 : int'(c) + 1) : 0;
    pr = state == STREAM ? (int'(c) == PN - 1 ? int'(r) + 1 : int'(r)) : 0;
    ir = pr - PADDING;
    ic = pc - PADDING;
    p_in = ir >= 0 && ir < FM_SIZE && ic >= 0 && ic < FM_SIZE;
    p_addr = FA_W'(ir * FM_SIZE + ic);
  end
  // read data returns one cycle after issue, so the sample is muxed straight from memory
  assign o_pe_data = o_pe_en ? (pad_q ? '0 : i_fm_data) : last_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      w_cnt <= '0;
      r <= '0;
      c <= '0;
      res_cnt <= '0;
      pad_q <= 1'b0;
      last_q <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_w_addr <= '0;
      o_fm_addr <= '0;
      o_fm_rd <= 1'b0;
      o_weight <= '0;
      o_pe_en <= 1'b0;
      o_res_addr <= '0;
      o_res_wr <= 1'b0;
      o_res_data <= '0;
`ifdef CONV_SEQ_CTRL_TIMEOUT_EN
      idle_cnt <= '0;
      o_err <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      o_pe_en <= state == STREAM;
      pad_q <= !o_fm_rd;
      if (o_pe_en) last_q <= o_pe_data;
      o_res_wr <= 1'b0;
      if ((state == STREAM || state == DRAIN) && i_res_en && int'(res_cnt) < NRES) begin
        o_res_wr <= 1'b1;
        o_res_addr <= RA_W'(res_cnt);
        o_res_data <= i_res_data;
        res_cnt <= res_cnt + 1'b1;
      end
      case (state)
        IDLE: if (i_go) begin
          state <= LOAD_W;
          o_busy <= 1'b1;
          w_cnt <= '0;
          o_w_addr <= '0;
          res_cnt <= '0;
`ifdef CONV_SEQ_CTRL_TIMEOUT_EN
          idle_cnt <= '0;
          o_err <= 1'b0;
`endif
        end
        LOAD_W: begin
          w_cnt <= w_cnt + 1'b1;
          if (int'(w_cnt) < KK - 1) o_w_addr <= o_w_addr + 1'b1;
          if (w_cnt != '0) o_weight[(int'(w_cnt) - 1) * WEIGHT_W +: WEIGHT_W] <= i_w_data;
          if (int'(w_cnt) == KK) begin
            state <= STREAM;
            r <= '0;
            c <= '0;
            o_fm_rd <= p_in;
            if (p_in) o_fm_addr <= p_addr;
          end
        end
        STREAM: if (last_pos) begin
          state <= DRAIN;
          o_fm_rd <= 1'b0;
        end else begin
          r <= RC_W'(pr);
          c <= RC_W'(pc);
          o_fm_rd <= p_in;
          if (p_in) o_fm_addr <= p_addr;
        end
        DRAIN: begin
          if (int'(res_cnt) == NRES) state <= DONE;
`ifdef CONV_SEQ_CTRL_TIMEOUT_EN
          else if (!i_res_en && idle_cnt == 16'd1022) begin
            state <= DONE;
            o_err <= 1'b1;
          end
          idle_cnt <= i_res_en ? '0 : idle_cnt + 1'b1;
`endif
        end
        DONE: begin
          state <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed bench for conv_seq_ctrl, default geometry plus a PADDING=1 instance.
module tb_conv_seq_ctrl;
  logic clk = 0, rst = 1, go = 0, go_p = 0, res_en = 0, res_en_p = 0;
  logic [47:0] res_data = 0, res_data_p = 0, res_q, res_q_p;
  logic [3:0] w_addr, w_addr_p, fm_addr, fm_addr_p, res_addr_p;
  logic [1:0] res_addr;
  logic [17:0] w_data, w_data_p;
  logic [29:0] fm_data, fm_data_p, pe_data, pe_data_p;
  logic [161:0] weight, weight_p;
  logic fm_rd, fm_rd_p, pe_en, pe_en_p, res_wr, res_wr_p, busy, busy_p, done, done_p, err, err_p;
  logic [17:0] wmem [9];
  logic [29:0] fmem [16];
  int total = 0, bad = 0;
  int pe_n, rd_n, dn, da, n;

  conv_seq_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .o_busy(busy), .o_done(done), .o_err(err),
    .o_w_addr(w_addr), .i_w_data(w_data), .o_fm_addr(fm_addr), .o_fm_rd(fm_rd), .i_fm_data(fm_data),
    .o_weight(weight), .o_pe_data(pe_data), .o_pe_en(pe_en), .i_res_en(res_en), .i_res_data(res_data),
    .o_res_addr(res_addr), .o_res_wr(res_wr), .o_res_data(res_q));

  conv_seq_ctrl #(.PADDING(1)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_go(go_p), .o_busy(busy_p), .o_done(done_p), .o_err(err_p),
    .o_w_addr(w_addr_p), .i_w_data(w_data_p), .o_fm_addr(fm_addr_p), .o_fm_rd(fm_rd_p), .i_fm_data(fm_data_p),
    .o_weight(weight_p), .o_pe_data(pe_data_p), .o_pe_en(pe_en_p), .i_res_en(res_en_p), .i_res_data(res_data_p),
    .o_res_addr(res_addr_p), .o_res_wr(res_wr_p), .o_res_data(res_q_p));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_data <= wmem[w_addr];
    w_data_p <= wmem[w_addr_p];
    if (fm_rd) fm_data <= fmem[fm_addr];
    if (fm_rd_p) fm_data_p <= fmem[fm_addr_p];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rv(input int k);
    return 48'h8000_0000_0000 | 48'(k * 13 + 1);
  endfunction

  function automatic logic [29:0] pad_exp(input int s);
    int pr = s / 6, pc = s % 6;
    return (pr >= 1 && pr <= 4 && pc >= 1 && pc <= 4) ? fmem[(pr - 1) * 4 + pc - 1] : 30'd0;
  endfunction

  // one full default-geometry pass with timing-exact checks
  task automatic do_pass(input bit go_mid, input int extra);
    int pn = 0, rn = 0, rise = 0, d_n = 0, d_at = -1;
    logic prev = 0;
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    chk("busy_load", 64'(busy), 64'(1));
    for (int t = 0; t < 9; t++) begin
      chk($sformatf("w_addr%0d", t), 64'(w_addr), 64'(t));
      @(negedge clk);
    end
    @(negedge clk);
    for (int j = 0; j < 9; j++) chk($sformatf("w_slot%0d", j), 64'(weight[j*18 +: 18]), 64'(j + 1));
    for (int i = 0; i < 20; i++) begin
      if (go_mid) go = (i == 3 || i == 4);
      if (fm_rd) begin
        chk("fm_addr", 64'(fm_addr), 64'(rn));
        rn++;
      end
      if (pe_en) begin
        chk($sformatf("sample%0d", pn), 64'(pe_data), 64'(fmem[pn]));
        pn++;
      end
      if (pe_en && !prev) rise++;
      prev = pe_en;
      @(negedge clk);
    end
    go = 0;
    chk("pe_cnt", 64'(pn), 64'(16));
    chk("rd_cnt", 64'(rn), 64'(16));
    chk("pe_runs", 64'(rise), 64'(1));
    chk("pe_hold", 64'(pe_data), 64'(fmem[15]));
    chk("busy_drain", 64'(busy), 64'(1));
    chk("err_low", 64'(err), 64'(0));
    for (int k = 0; k < 4; k++) begin
      res_en = 1;
      res_data = rv(k);
      @(negedge clk);
      chk($sformatf("res_wr%0d", k), 64'(res_wr), 64'(1));
      chk($sformatf("res_addr%0d", k), 64'(res_addr), 64'(k));
      chk($sformatf("res_data%0d", k), 64'(res_q), 64'(rv(k)));
    end
    res_en = extra > 0;
    res_data = 48'hDEAD;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        d_n++;
        if (d_at < 0) d_at = i;
      end
      chk("res_drop", 64'(res_wr), 64'(0));
      res_en = (i + 1 < extra);
    end
    res_en = 0;
    chk("done_pulses", 64'(d_n), 64'(1));
    chk("done_time", 64'(d_at), 64'(1));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    for (int j = 0; j < 9; j++) wmem[j] = 18'(j + 1);
    for (int j = 0; j < 16; j++) fmem[j] = 30'h0ABC_0100 + 30'(j * 3);
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_weight", 64'(weight == '0), 64'(1));
    chk("rst_pe_en", 64'(pe_en), 64'(0));
    chk("rst_pe_data", 64'(pe_data), 64'(0));
    chk("rst_fm_rd", 64'(fm_rd), 64'(0));
    chk("rst_res_wr", 64'(res_wr), 64'(0));
    chk("rst_err", 64'(err), 64'(0));

    do_pass(0, 0);
    do_pass(1, 6);
    do_pass(0, 0);

    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    repeat (14) @(negedge clk);
    chk("pre_rst_rd", 64'(fm_rd), 64'(1));
    chk("pre_rst_addr", 64'(fm_addr), 64'(4));
    rst = 1;
    @(negedge clk) rst = 0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_fm_rd", 64'(fm_rd), 64'(0));
    chk("mid_rst_fm_addr", 64'(fm_addr), 64'(0));
    chk("mid_rst_w_addr", 64'(w_addr), 64'(0));
    chk("mid_rst_pe_en", 64'(pe_en), 64'(0));
    chk("mid_rst_pe_data", 64'(pe_data), 64'(0));
    chk("mid_rst_weight", 64'(weight == '0), 64'(1));
    chk("mid_rst_done", 64'(done), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(done), 64'(0));
    end
    do_pass(0, 0);

    @(negedge clk) go_p = 1;
    @(negedge clk) go_p = 0;
    repeat (10) @(negedge clk);
    for (int j = 0; j < 9; j++) chk($sformatf("p_w_slot%0d", j), 64'(weight_p[j*18 +: 18]), 64'(j + 1));
    pe_n = 0;
    rd_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fm_rd_p) begin
        chk("p_fm_addr", 64'(fm_addr_p), 64'(rd_n));
        rd_n++;
      end
      if (pe_en_p) begin
        chk($sformatf("p_sample%0d", pe_n), 64'(pe_data_p), 64'(pad_exp(pe_n)));
        pe_n++;
      end
      @(negedge clk);
    end
    chk("p_pe_cnt", 64'(pe_n), 64'(36));
    chk("p_rd_cnt", 64'(rd_n), 64'(16));
    for (int k = 0; k < 16; k++) begin
      res_en_p = 1;
      res_data_p = rv(k);
      @(negedge clk);
      chk($sformatf("p_res_addr%0d", k), 64'(res_addr_p), 64'(k));
      chk($sformatf("p_res_data%0d", k), 64'(res_q_p), 64'(rv(k)));
    end
    res_en_p = 0;
    dn = 0;
    da = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_p) begin
        dn++;
        if (da < 0) da = i;
      end
    end
    chk("p_done_pulses", 64'(dn), 64'(1));
    chk("p_done_time", 64'(da), 64'(1));
    chk("p_busy_idle", 64'(busy_p), 64'(0));

`ifdef CONV_SEQ_CTRL_TIMEOUT_EN
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    repeat (30) @(negedge clk);
    res_en = 1;
    res_data = rv(0);
    repeat (2) @(negedge clk);
    res_en = 0;
    n = 0;
    while (!done && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("to_wait_range", 64'(n >= 1015 && n <= 1035), 64'(1));
    chk("to_done", 64'(done), 64'(1));
    chk("to_err", 64'(err), 64'(1));
    @(negedge clk);
    chk("to_err_hold", 64'(err), 64'(1));
    chk("to_busy", 64'(busy), 64'(0));
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    chk("to_err_clear", 64'(err), 64'(0));
    rst = 1;
    @(negedge clk) rst = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
